// File: rtl/instruction_cache.sv
// instruction_cache -- direct-mapped instruction cache, 2**INDEX_BITS lines of
// 128 bits each, refilled a whole block at a time from instruction memory.
//
// Ports:
//   clock        single clock, all state updates on its rising edge
//   reset        asynchronous, active-high
//   req          fetch request from the fetch stage
//   address      byte address of the requested instruction ([1:0] ignored)
//   instruction  selected word on a hit, 0 otherwise
//   instr_ready  combinational hit indication for the current req/address
//   mem_enable   block read request to instruction memory (high in FILL only)
//   mem_address  block-aligned fill address, held for the whole fill
//   mem_data     returned block, word 0 in [31:0]
//   mem_valid    one-cycle pulse qualifying mem_data
//   hit_count    (ICACHE_STATS_EN only) IDLE cycles with a hit
//   miss_count   (ICACHE_STATS_EN only) IDLE->FILL transitions
//
// Build option: define ICACHE_STATS_EN to add the hit/miss statistics counters.

module instruction_cache #(
  parameter int INDEX_BITS = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         instr_ready,
  output logic         mem_enable,
  output logic [31:0]  mem_address,
  input  logic [127:0] mem_data,
  input  logic         mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, RELEASE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [127:0]     data_arr [LINES];

  logic [1:0]            word;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic [1:0]            unused_addr_bits;
  logic                  hit;
  logic                  miss;
  logic                  install;

  assign word             = address[3:2];
  assign index            = address[3+INDEX_BITS:4];
  assign tag              = address[31:4+INDEX_BITS];
  assign unused_addr_bits = address[1:0];

  // The line being filled is addressed from the latched fill address, so the
  // install still lands correctly if the requester drops req mid-fill.
  assign fill_index = mem_address[3+INDEX_BITS:4];
  assign fill_tag   = mem_address[31:4+INDEX_BITS];

  assign hit     = (state_q == IDLE) && req && valid_q[index] && (tag_arr[index] == tag);
  assign miss    = (state_q == IDLE) && req && !hit;
  // mem_valid outside FILL (including the memory's power-up pulse) is ignored.
  assign install = (state_q == FILL) && mem_valid;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss)      state_d = FILL;
      FILL:    if (mem_valid) state_d = RELEASE;
      // One cycle with mem_enable low so the next miss presents a fresh edge.
      RELEASE:                state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_enable  = (state_q == FILL);
    instr_ready = hit;
    instruction = '0;
    if (hit) instruction = data_arr[index][{word, 5'b0} +: 32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address <= '0;
      valid_q     <= '0;
    end else begin
      if (miss)    mem_address         <= {address[31:4], 4'b0};
      if (install) valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clock) begin
    if (install) begin
      tag_arr[fill_index]  <= fill_tag;
      data_arr[fill_index] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss/refill, same-line hits,
// conflict eviction, stray mem_valid pulses, reset during a fill, req dropped
// during a fill, and (with ICACHE_STATS_EN) the statistics counters.

module tb_instruction_cache;

  logic         clock;
  logic         reset;
  logic         req;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         instr_ready;
  logic         mem_enable;
  logic [31:0]  mem_address;
  logic [127:0] mem_data;
  logic         mem_valid;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int rises       = 0;
  int r0;

  localparam logic [127:0] D00 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
  localparam logic [127:0] D40 = 128'h44440003_33330002_22220001_11110000;
  localparam logic [127:0] D20 = 128'h2020000D_2020000C_2020000B_2020000A;
  localparam logic [127:0] D30 = 128'h3030000D_3030000C_3030000B_3030000A;
  localparam logic [127:0] D10 = 128'h1010000D_1010000C_1010000B_1010000A;
  localparam logic [127:0] JNK = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  instruction_cache #(.INDEX_BITS(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .address     (address),
    .instruction (instruction),
    .instr_ready (instr_ready),
    .mem_enable  (mem_enable),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge mem_enable) rises++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full miss: miss cycle, two FILL cycles (mem_valid in the second),
  // RELEASE, then the retried request hits and returns exp_word.
  task automatic fetch_miss(input string nm, input logic [31:0] a,
                            input logic [31:0] blk, input logic [127:0] d,
                            input logic [31:0] exp_word);
    req = 1'b1; address = a;
    #1;
    chk({nm, "_miss_ready"}, {31'b0, instr_ready}, 32'd0);
    chk({nm, "_miss_men"},   {31'b0, mem_enable},  32'd0);
    tick();
    #1;
    chk({nm, "_fill_men"},   {31'b0, mem_enable},  32'd1);
    chk({nm, "_fill_addr"},  mem_address,          blk);
    chk({nm, "_fill_ready"}, {31'b0, instr_ready}, 32'd0);
    tick();
    mem_valid = 1'b1; mem_data = d;
    #1;
    chk({nm, "_fill_hold"},  mem_address,          blk);
    tick();
    mem_valid = 1'b0; mem_data = JNK;
    #1;
    chk({nm, "_rel_men"},    {31'b0, mem_enable},  32'd0);
    chk({nm, "_rel_ready"},  {31'b0, instr_ready}, 32'd0);
    tick();
    #1;
    chk({nm, "_hit_ready"},  {31'b0, instr_ready}, 32'd1);
    chk({nm, "_hit_instr"},  instruction,          exp_word);
    tick();
    req = 1'b0;
  endtask

  task automatic fetch_hit(input string nm, input logic [31:0] a, input logic [31:0] exp_word);
    req = 1'b1; address = a;
    #1;
    chk({nm, "_ready"}, {31'b0, instr_ready}, 32'd1);
    chk({nm, "_instr"}, instruction,          exp_word);
    chk({nm, "_men"},   {31'b0, mem_enable},  32'd0);
    tick();
  endtask

  initial begin
    // Reset, with a request pending and a power-up mem_valid pulse.
    reset = 1'b1; req = 1'b1; address = 32'h8;
    mem_valid = 1'b1; mem_data = JNK;
    tick();
    tick();
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_instr", instruction,          32'd0);
    chk("rst_men",   {31'b0, mem_enable},  32'd0);
    chk("rst_maddr", mem_address,          32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hits",  hit_count,  32'd0);
    chk("rst_miss",  miss_count, 32'd0);
`endif
    reset = 1'b0; req = 1'b0; mem_valid = 1'b0;
    tick();
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();

    // Cold fetch at 0x8: one mem_enable rise, word 2 of the block.
    r0 = rises;
    fetch_miss("cold8", 32'h8, 32'h0, D00, 32'hCCCC0002);
    chk("cold8_rises", rises - r0, 32'd1);

    // Same-line hits.
    fetch_hit("hit0", 32'h0, 32'hAAAA0000);
    fetch_hit("hit4", 32'h4, 32'hBBBB0001);
    fetch_hit("hitC", 32'hC, 32'hDDDD0003);
    req = 1'b0;
    #1;
    chk("hits_rises", rises - r0, 32'd1);
`ifdef ICACHE_STATS_EN
    chk("stat_miss", miss_count, 32'd1);
    chk("stat_hits", hit_count,  32'd4);
`endif
    tick();

    // Conflict: 0x40 shares index 0 with 0x0; 0x0 must then miss again.
    fetch_miss("conf40", 32'h40, 32'h40, D40, 32'h11110000);
    fetch_miss("back0",  32'h0,  32'h0,  D00, 32'hAAAA0000);

    // Stray mem_valid in IDLE leaves line 0 intact and installs nothing.
    mem_valid = 1'b1; mem_data = JNK;
    tick();
    mem_valid = 1'b0;
    fetch_hit("stray_keep0", 32'h0, 32'hAAAA0000);
    req = 1'b0;
    tick();
    fetch_miss("stray24", 32'h24, 32'h20, D20, 32'h2020000B);

    // Reset in the middle of a fill, then a late mem_valid, then retry.
    req = 1'b1; address = 32'h3C;
    tick();
    #1;
    chk("abort_fill_men", {31'b0, mem_enable}, 32'd1);
    r0 = rises;
    reset = 1'b1;
    #1;
    chk("abort_rst_men",   {31'b0, mem_enable}, 32'd0);
    chk("abort_rst_maddr", mem_address,         32'd0);
    tick();
    reset = 1'b0; req = 1'b0;
    mem_valid = 1'b1; mem_data = JNK;
    tick();
    mem_valid = 1'b0;
    tick();
    fetch_miss("retry3C", 32'h3C, 32'h30, D30, 32'h3030000D);
    chk("retry_rises", rises - r0, 32'd1);

    // req dropped during FILL: line still installed.
    req = 1'b1; address = 32'h10;
    #1;
    chk("drop_miss", {31'b0, instr_ready}, 32'd0);
    tick();
    req = 1'b0; mem_valid = 1'b1; mem_data = D10;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("drop_rel_men", {31'b0, mem_enable}, 32'd0);
    tick();
    tick();
    fetch_hit("drop_hit14", 32'h14, 32'h1010000B);
    req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter: INDEX_BITS, 2, log2 of line count (4 lines of 128 bits, direct-mapped).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  fetch request from the fetch stage.
REQ-005 address  input  32  byte address of the requested instruction; bits [1:0] ignored.
REQ-006 instruction  output  32  requested instruction word; 0 when instr_ready is low.
REQ-007 instr_ready  output  1  high when instruction is valid for the current req/address.
REQ-008 mem_enable  output  1  read request to the instruction memory; memory acts on its rising edge.
REQ-009 mem_address  output  32  block-aligned fill address, {address[31:4], 4'b0}.
REQ-010 mem_data  input  128  returned block; word 0 in bits [31:0], word 3 in bits [127:96].
REQ-011 mem_valid  input  1  one-cycle pulse marking mem_data valid.

Function
REQ-012 Address split SHALL be: word = address[3:2], index = address[3+INDEX_BITS:4], tag = address[31:4+INDEX_BITS].
REQ-013 Each line SHALL hold a valid bit, a tag and 128 data bits.
REQ-014 The FSM SHALL have exactly these states: IDLE, FILL, RELEASE.
REQ-015 In IDLE, a hit (req high, line valid, tag equal) SHALL drive instr_ready high combinationally in the same cycle, with instruction equal to the selected word.
REQ-016 In IDLE, a miss (req high, no hit) SHALL hold instr_ready low and move to FILL on the next edge, latching mem_address from address.
REQ-017 In FILL, mem_enable SHALL be high and mem_address SHALL be held constant.
REQ-018 In FILL, on an edge where mem_valid is high, the cache SHALL write mem_data, the tag and valid=1 into the indexed line, then move to RELEASE.
REQ-019 In RELEASE, mem_enable SHALL be low for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 The low mem_enable cycle in RELEASE guarantees that the memory sees a fresh rising edge on the next miss.
REQ-021 instr_ready SHALL be low in FILL and RELEASE.
REQ-022 The retried request SHALL hit in IDLE, two cycles after the mem_valid cycle.
REQ-023 mem_enable SHALL be low in IDLE.
REQ-024 Any mem_valid in IDLE or RELEASE, including the memory's spurious power-up pulse, SHALL be ignored and SHALL NOT modify any line.
REQ-025 The requester SHALL hold req and address stable while instr_ready is low.
REQ-026 If req drops during FILL, the fill SHALL still complete and the line SHALL be installed.
REQ-027 A fill to an index already holding a valid line SHALL overwrite it; there is no write-back.

Reset
REQ-028 While reset is high: FSM state = IDLE, all valid bits = 0, mem_enable = 0, mem_address = 0, instr_ready = 0, instruction = 0.
REQ-029 Reset during FILL SHALL abandon the fill; a mem_valid pulse arriving after reset release SHALL be ignored per REQ-024.
REQ-030 Tag and data arrays need not be reset.

Configuration
REQ-031 Macro ICACHE_STATS_EN enables the statistics feature.
REQ-032 With ICACHE_STATS_EN defined: 32-bit outputs hit_count and miss_count are present.
REQ-033 hit_count SHALL increment once per IDLE cycle with a hit.
REQ-034 miss_count SHALL increment once on each IDLE->FILL transition.
REQ-035 Both counters SHALL reset to 0 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-036 Without ICACHE_STATS_EN: the counter ports and logic are absent; all other behaviour is identical.

Verification
REQ-037 Cold fetch at 0x00000008 -> exactly one mem_enable rise with mem_address 0x00000000; instr_ready high 2 cycles after mem_valid; instruction = mem_data[95:64].
REQ-038 After REQ-037, fetches at 0x0, 0x4 and 0xC -> instr_ready high in the same cycle each time; mem_enable stays low.
REQ-039 Fetch at 0x40 after 0x0 is cached -> same index, new tag; refill from 0x40; a subsequent fetch at 0x0 misses again.
REQ-040 mem_valid pulsed in IDLE with arbitrary data -> no line valid; the next fetch still misses.
REQ-041 Reset asserted mid-FILL, released, then the same fetch issued -> mem_enable shows a new rising edge; correct data returned.
REQ-042 With ICACHE_STATS_EN, sequence from REQ-037 then REQ-038 -> miss_count = 1, hit_count = 4.
